// File: rtl/mem_lsu.sv
// mem_lsu - load/store unit for the MEM pipeline stage.
//
// Accepts one instruction per cycle from EX while idle, runs a
// request/grant/response handshake with the data memory for loads and
// stores, aborts accesses that overrun TIMEOUT cycles, and reports
// misaligned accesses. Loads are lane-aligned big-endian (byte offset 0
// is [31:24]); stores get lane-replicated data and byte enables.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   in_valid/op/addr/     instruction from EX (op 0 NONE, 1 LB, 2 LBU,
//   wdata/wreg/regwrite     3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9-15 NONE)
//   stall_out             upstream must hold its instruction
//   dm_req/we/addr/be/    data-memory request (held until dm_gnt)
//   wdata, dm_gnt
//   dm_rvalid/rdata       data-memory load response
//   wb_valid/reg/         registered writeback pulse to WB
//   regwrite/data
//   exc_valid/code/addr   registered exception pulse (01 misaligned,
//                         10 timeout)
//
// States:
//   state  | meaning
//   IDLE   | ready to accept; NONE and misaligned ops retire from here
//   REQ    | dm_req asserted, waiting for dm_gnt
//   WAIT   | load granted, waiting for dm_rvalid

module mem_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_wreg,
    input  logic              in_regwrite,
    output logic              stall_out,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [31:0]       dm_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic              wb_regwrite,
    output logic [31:0]       wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_code,
    output logic [ADDR_W-1:0] exc_addr
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    // Wide enough to hold TIMEOUT itself; with TIMEOUT=0 the counter is
    // free-running and never compared.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nx;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_tmo;

    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [4:0]          r_wreg;
    logic                r_regwrite;
    logic                w_latch;

    logic                r_wb_valid;
    logic [4:0]          r_wb_reg;
    logic                r_wb_regwrite;
    logic [31:0]         r_wb_data;
    logic                r_exc_valid;
    logic [1:0]          r_exc_code;
    logic [ADDR_W-1:0]   r_exc_addr;

    logic                w_wb_valid_nx;
    logic [4:0]          w_wb_reg_nx;
    logic                w_wb_regwrite_nx;
    logic [31:0]         w_wb_data_nx;
    logic                w_exc_valid_nx;
    logic [1:0]          w_exc_code_nx;
    logic [ADDR_W-1:0]   w_exc_addr_nx;

    logic                w_in_mem;
    logic                w_in_misal;
    logic [31:0]         w_addr_zx;
    logic                w_is_store;
    logic                w_in_req;
    logic [3:0]          w_be;
    logic [31:0]         w_st_data;
    logic [7:0]          w_ld_byte;
    logic [15:0]         w_ld_half;
    logic [31:0]         w_ld_data;

    // NONE writes back the ALU result carried on in_addr, zero-extended
    // (or truncated) to the 32-bit register width.
    generate
        if (ADDR_W >= 32) begin : g_addr_trunc
            assign w_addr_zx = in_addr[31:0];
        end else begin : g_addr_zext
            assign w_addr_zx = {{(32 - ADDR_W){1'b0}}, in_addr};
        end
    endgenerate

    assign w_in_mem = (in_op >= OP_LB) && (in_op <= OP_SW);

    always_comb begin
        w_in_misal = 1'b0;
        case (in_op)
            OP_LH, OP_LHU, OP_SH: w_in_misal = in_addr[0];
            OP_LW, OP_SW:         w_in_misal = |in_addr[1:0];
            default:              w_in_misal = 1'b0;
        endcase
    end

    assign w_is_store = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);

    // Store lane steering from the latched instruction; loads read a full word.
    always_comb begin
        w_be      = 4'b1111;
        w_st_data = 32'h0;
        case (r_op)
            OP_SB: begin
                w_be      = 4'b1000 >> r_addr[1:0];
                w_st_data = {4{r_wdata[7:0]}};
            end
            OP_SH: begin
                w_be      = r_addr[1] ? 4'b0011 : 4'b1100;
                w_st_data = {2{r_wdata[15:0]}};
            end
            OP_SW: begin
                w_be      = 4'b1111;
                w_st_data = r_wdata;
            end
            default: begin
                w_be      = 4'b1111;
                w_st_data = 32'h0;
            end
        endcase
    end

    // Big-endian load alignment: offset 0 is the most significant lane.
    always_comb begin
        w_ld_byte = 8'h0;
        case (r_addr[1:0])
            2'd0: w_ld_byte = dm_rdata[31:24];
            2'd1: w_ld_byte = dm_rdata[23:16];
            2'd2: w_ld_byte = dm_rdata[15:8];
            default: w_ld_byte = dm_rdata[7:0];
        endcase
        w_ld_half = r_addr[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        case (r_op)
            OP_LB:   w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            OP_LBU:  w_ld_data = {24'h0, w_ld_byte};
            OP_LH:   w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            OP_LHU:  w_ld_data = {16'h0, w_ld_half};
            default: w_ld_data = dm_rdata;
        endcase
    end

    // Memory request outputs are gated by the REQ state so that reset
    // (which forces IDLE asynchronously) drops them immediately.
    assign w_in_req  = (r_state == S_REQ);
    assign stall_out = (r_state != S_IDLE);
    assign dm_req    = w_in_req;
    assign dm_we     = w_in_req && w_is_store;
    assign dm_addr   = w_in_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dm_be     = w_in_req ? w_be : 4'b0000;
    assign dm_wdata  = w_in_req ? w_st_data : 32'h0;

    // The cycle being spent in REQ/WAIT is the TIMEOUT-th one.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_latch          = 1'b0;
        w_wb_valid_nx    = 1'b0;
        w_wb_reg_nx      = 5'd0;
        w_wb_regwrite_nx = 1'b0;
        w_wb_data_nx     = 32'h0;
        w_exc_valid_nx   = 1'b0;
        w_exc_code_nx    = 2'b00;
        w_exc_addr_nx    = '0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_latch  = 1'b1;
                    w_cnt_nx = '0;
                    if (!w_in_mem) begin
                        w_wb_valid_nx    = 1'b1;
                        w_wb_reg_nx      = in_wreg;
                        w_wb_regwrite_nx = in_regwrite;
                        w_wb_data_nx     = w_addr_zx;
                    end else if (w_in_misal) begin
                        w_wb_valid_nx  = 1'b1;
                        w_wb_reg_nx    = in_wreg;
                        w_exc_valid_nx = 1'b1;
                        w_exc_code_nx  = EXC_MISALIGN;
                        w_exc_addr_nx  = in_addr;
                    end else begin
                        w_state_nx = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_cnt_nx = w_cnt_inc;
                // Grant takes priority over a coincident timeout.
                if (dm_gnt) begin
                    if (w_is_store) begin
                        w_state_nx    = S_IDLE;
                        w_wb_valid_nx = 1'b1;
                        w_wb_reg_nx   = r_wreg;
                    end else begin
                        w_state_nx = S_WAIT;
                    end
                end else if (w_tmo) begin
                    w_state_nx     = S_IDLE;
                    w_wb_valid_nx  = 1'b1;
                    w_wb_reg_nx    = r_wreg;
                    w_exc_valid_nx = 1'b1;
                    w_exc_code_nx  = EXC_TIMEOUT;
                    w_exc_addr_nx  = r_addr;
                end
            end
            S_WAIT: begin
                w_cnt_nx = w_cnt_inc;
                // Returning data takes priority over a coincident timeout.
                if (dm_rvalid) begin
                    w_state_nx       = S_IDLE;
                    w_wb_valid_nx    = 1'b1;
                    w_wb_reg_nx      = r_wreg;
                    w_wb_regwrite_nx = r_regwrite;
                    w_wb_data_nx     = w_ld_data;
                end else if (w_tmo) begin
                    w_state_nx     = S_IDLE;
                    w_wb_valid_nx  = 1'b1;
                    w_wb_reg_nx    = r_wreg;
                    w_exc_valid_nx = 1'b1;
                    w_exc_code_nx  = EXC_TIMEOUT;
                    w_exc_addr_nx  = r_addr;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_op          <= OP_NONE;
            r_addr        <= '0;
            r_wdata       <= 32'h0;
            r_wreg        <= 5'd0;
            r_regwrite    <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_reg      <= 5'd0;
            r_wb_regwrite <= 1'b0;
            r_wb_data     <= 32'h0;
            r_exc_valid   <= 1'b0;
            r_exc_code    <= 2'b00;
            r_exc_addr    <= '0;
        end else begin
            if (w_latch) begin
                r_op       <= in_op;
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_wreg     <= in_wreg;
                r_regwrite <= in_regwrite;
            end
            r_wb_valid    <= w_wb_valid_nx;
            r_wb_reg      <= w_wb_reg_nx;
            r_wb_regwrite <= w_wb_regwrite_nx;
            r_wb_data     <= w_wb_data_nx;
            r_exc_valid   <= w_exc_valid_nx;
            r_exc_code    <= w_exc_code_nx;
            r_exc_addr    <= w_exc_addr_nx;
        end
    end

    assign wb_valid    = r_wb_valid;
    assign wb_reg      = r_wb_reg;
    assign wb_regwrite = r_wb_regwrite;
    assign wb_data     = r_wb_data;
    assign exc_valid   = r_exc_valid;
    assign exc_code    = r_exc_code;
    assign exc_addr    = r_exc_addr;

endmodule
